// File: rtl/median_window_gen_if.sv
// Pixel stream in, 3x3 window stream out, for the median window generator.
interface median_window_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      in_valid;
    logic                      in_sof;
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      win_valid;
    logic [9*DATA_WIDTH-1:0]   win_data;

    // Pixel source / window sink side.
    modport master (
        output in_valid, in_sof, in_data,
        input  win_valid, win_data
    );

    // Window generator side.
    modport slave (
        input  in_valid, in_sof, in_data,
        output win_valid, win_data
    );
endinterface

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus three column shift
// registers. One window is emitted per fully populated position, one cycle
// after the pixel that completes it.
module median_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int COL_BITS   = 10
) (
    input logic               clk,
    input logic               rst,
    median_window_gen_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [COL_BITS-1:0] MIN_COL  = COL_BITS'(2);

    typedef logic [DW-1:0] pix_t;

    // Line buffers: lb1 holds the previous line, lb2 the line before that.
    pix_t lb1_mem [IMG_WIDTH];
    pix_t lb2_mem [IMG_WIDTH];

    logic [COL_BITS-1:0] col_q, col_d, cur_col;
    logic [1:0]          row_q, row_d, cur_row;

    // Column shift registers, index 0 = oldest (left) column.
    pix_t top_q [3];
    pix_t mid_q [3];
    pix_t bot_q [3];
    pix_t top_d [3];
    pix_t mid_d [3];
    pix_t bot_d [3];

    pix_t lb1_rd, lb2_rd;

    logic              win_valid_q, win_valid_d;
    logic [9*DW-1:0]   win_data_q,  win_data_d;

    // Next-state logic: counters, shifted columns and the window to publish.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        // A start-of-frame pixel is (0,0) whatever the counters say.
        cur_col = bus.in_sof ? '0 : col_q;
        cur_row = bus.in_sof ? '0 : row_q;

        // Read-before-write: the old contents are what this pixel sees.
        lb1_rd = lb1_mem[cur_col];
        lb2_rd = lb2_mem[cur_col];

        col_d       = col_q;
        row_d       = row_q;
        top_d       = top_q;
        mid_d       = mid_q;
        bot_d       = bot_q;
        win_valid_d = 1'b0;
        win_data_d  = win_data_q;

        if (bus.in_valid) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
            end else begin
                col_d = cur_col + COL_BITS'(1);
                row_d = cur_row;
            end

            top_d = '{top_q[1], top_q[2], lb2_rd};
            mid_d = '{mid_q[1], mid_q[2], lb1_rd};
            bot_d = '{bot_q[1], bot_q[2], bus.in_data};

            // Only positions with two full lines and two columns behind them.
            if (cur_row == 2'd2 && cur_col >= MIN_COL) begin
                win_valid_d = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    win_data_d[c*DW +: DW]     = top_d[c];
                    win_data_d[(3+c)*DW +: DW] = mid_d[c];
                    win_data_d[(6+c)*DW +: DW] = bot_d[c];
                end
            end
        end
    end

    // State registers with synchronous reset; reset drops a same-cycle pixel.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            top_q       <= '{default: '0};
            mid_q       <= '{default: '0};
            bot_q       <= '{default: '0};
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            top_q       <= top_d;
            mid_q       <= mid_d;
            bot_q       <= bot_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
        end
    end

    // Line-buffer writes: age lb1 into lb2 and store the incoming pixel.
    // NOTE: the RAMs are deliberately not reset; row/column gating keeps stale data out.
    always_ff @(posedge clk) begin
        if (bus.in_valid && !rst) begin
            lb2_mem[cur_col] <= lb1_rd;
            lb1_mem[cur_col] <= bus.in_data;
        end
    end

    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_data_q;
endmodule

// File: doc/median_window_gen.md
# median_window_gen

Streaming 3x3 window generator that feeds the median filter's compare-and-swap sorting network. It accepts one pixel per cycle in raster order, stores the two previous image lines in on-chip line buffers and presents a complete 3x3 neighbourhood, registered, to the downstream median stage. Windows are emitted only for fully populated positions, so no border pixels are ever synthesised.

## Interface

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per line (>= 3); sets line-buffer depth and column wrap.
- COL_BITS, 10, column counter width; must satisfy 2^COL_BITS >= IMG_WIDTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  pixel strobe; in_data accepted on every cycle it is high (no backpressure).
- in_sof  input  1  start of frame; qualified by in_valid; marks pixel (row 0, col 0).
- in_data  input  DATA_WIDTH  pixel value.
- win_valid  output  1  win_data holds a new complete window this cycle (one-cycle pulse per window).
- win_data  output  9*DATA_WIDTH  window; element k = 3*r + c at bits [k*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest (top) row, c=0 the oldest (left) column; k=4 is the centre.

## Operation

- Counters: col (0..IMG_WIDTH-1), row_cnt (saturating at 2; only "0, 1, >=2" matters).
- Accepted pixel at (row, col): col increments; at IMG_WIDTH-1 it wraps to 0 and row_cnt increments (saturating).
- in_valid && in_sof: the pixel is (0,0) regardless of counter state; next col = 1, row_cnt = 0. in_sof without in_valid is ignored.
- Line buffers lb1 (previous line) and lb2 (line before that), each IMG_WIDTH x DATA_WIDTH, addressed by col: on acceptance read lb1[col], lb2[col], then write lb2[col] <= lb1[col], lb1[col] <= in_data (read-before-write, same cycle).
- Three 3-deep column shift registers (top = lb2 output, mid = lb1 output, bottom = in_data) shift by one on every accepted pixel only; they hold when in_valid is low.
- Window emitted when the accepted pixel has row_cnt >= 2 and col >= 2; the window covers rows row-2..row, cols col-2..col (centre at (row-1, col-1)).
- No window for col < 2 (shift registers still contain previous-line data) or row_cnt < 2; line-buffer contents are never cleared, gating alone guarantees stale data is not emitted.
- Per W x H frame: exactly (W-2)*(H-2) windows.
- Arithmetic: none on pixel data; values pass through unmodified.

## Timing

- Reset: win_valid = 0, win_data = 0, col = 0, row_cnt = 0, shift registers = 0; line-buffer RAM not reset.
- Latency: window for pixel accepted in cycle T appears on win_data with win_valid = 1 in cycle T+1.
- win_valid is high for exactly one cycle per window; win_data holds its last value while win_valid is low.
- Gaps in in_valid: no state change, win_valid = 0 during gap cycles.
- in_sof mid-line or mid-frame: counters restart immediately; next window earliest after new (2,2).
- rst mid-frame: takes priority over in_valid in the same cycle; the pixel is dropped; outputs as at reset; next frame must begin with in_sof or is counted from (0,0).
- Throughput: one pixel and at most one window per cycle.

## Test plan

- IMG_WIDTH=4, 4x4 frame, pixel = 16*row+col, continuous valid -> first win_valid one cycle after pixel 0x22 with win_data elements k0..k8 = 00,01,02,10,11,12,20,21,22 (centre 0x11); exactly 4 windows total, last = 11,12,13,21,22,23,31,32,33.
- Same frame with in_valid low every other cycle -> identical 4 windows in identical order; win_valid never high during gap cycles+1.
- Two back-to-back frames, second with values +0x80 -> second frame's first window is 80,81,82,90,91,92,A0,A1,A2; no window mixes frame-1 data.
- in_sof asserted at pixel (2,1) of frame 1 -> no window until new (2,2); no window from the aborted frame after the sof.
- rst asserted for 1 cycle after pixel (2,2) accepted -> win_valid = 0, win_data = 0 next cycle; restarted frame yields 4 correct windows.
- IMG_WIDTH=3, 3x3 frame all 0xFF with DATA_WIDTH=8 -> exactly one window, all nine elements 0xFF.
